// File: rtl/clint_arb_pkg.sv
// Shared types and constants for the CLINT bus arbiter.
package clint_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Read data returned on a watchdog completion (truncated to DATA_W).
    localparam logic [63:0] ERR_RDATA = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam logic [2:0] SIZE_W32 = 3'd2;
    localparam logic [2:0] SIZE_W64 = 3'd3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int c;
        c     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                idx_o    = IW'(c);
                gnt_o[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clint_bus_arbiter.sv
// Round-robin arbiter sharing the CLINT MMIO slave port between NUM_REQ requesters,
// one outstanding access, with a watchdog that completes hung accesses with an error.
module clint_bus_arbiter
    import clint_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int GID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         m_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  m_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  m_req_wdata,
    input  logic [NUM_REQ-1:0]         m_req_we,
    input  logic [NUM_REQ*3-1:0]       m_req_size,
    output logic [NUM_REQ-1:0]         m_req_ready,
    output logic [DATA_W-1:0]          m_req_rdata,
    output logic                       m_req_err,
    output logic                       s_req_valid,
    output logic [ADDR_W-1:0]          s_req_addr,
    output logic [DATA_W-1:0]          s_req_wdata,
    output logic                       s_req_we,
    output logic [2:0]                 s_req_size,
    input  logic                       s_req_ready,
    input  logic [DATA_W-1:0]          s_req_rdata,
    output logic                       busy,
    output logic [GID_W-1:0]           grant_id,
    output state_t                     dbg_state_o
);

    // Handshake: upstream, a request is taken on the IDLE edge where m_req_valid[i] is
    // high and i wins arbitration; the payload is captured then, and m_req_ready[i] pulses
    // for exactly one cycle at completion. Downstream, s_req_valid holds with a stable
    // payload until the edge where s_req_ready is high (or the watchdog expires).
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_M1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    state_t               state_q, state_d;
    logic                 s_valid_q, s_valid_d;
    logic [ADDR_W-1:0]    s_addr_q, s_addr_d;
    logic [DATA_W-1:0]    s_wdata_q, s_wdata_d;
    logic                 s_we_q, s_we_d;
    logic [2:0]           s_size_q, s_size_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic [GID_W-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]   gnt_oh_q, gnt_oh_d;
    logic [GID_W-1:0]     rr_q, rr_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [GID_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 wdog_hit;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (GID_W)
    ) u_rr_pick (
        .req_i (m_req_valid),
        .ptr_i (rr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign wdog_hit = (TIMEOUT_CYCLES != 0) && (wdog_q == WD_W'(TO_M1));

    always_comb begin
        state_d   = state_q;
        s_valid_d = s_valid_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_we_d    = s_we_q;
        s_size_d  = s_size_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        ready_d   = '0;
        grant_d   = grant_q;
        gnt_oh_d  = gnt_oh_q;
        rr_d      = rr_q;
        wdog_d    = wdog_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    s_valid_d = 1'b1;
                    s_addr_d  = m_req_addr[pick_idx*ADDR_W +: ADDR_W];
                    s_wdata_d = m_req_wdata[pick_idx*DATA_W +: DATA_W];
                    s_we_d    = m_req_we[pick_idx];
                    s_size_d  = m_req_size[pick_idx*3 +: 3];
                    grant_d   = pick_idx;
                    gnt_oh_d  = pick_gnt;
                    wdog_d    = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d = wdog_q + 1'b1;
                // Slave ready takes precedence over a watchdog expiry in the same cycle.
                if (s_req_ready) begin
                    s_valid_d = 1'b0;
                    rdata_d   = s_req_rdata;
                    err_d     = 1'b0;
                    ready_d   = gnt_oh_q;
                    state_d   = RESP;
                end else if (wdog_hit) begin
                    s_valid_d = 1'b0;
                    rdata_d   = DATA_W'(ERR_RDATA);
                    err_d     = 1'b1;
                    ready_d   = gnt_oh_q;
                    state_d   = RESP;
                end
            end
            RESP: begin
                err_d   = 1'b0;
                wdog_d  = '0;
                rr_d    = (grant_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            s_valid_q <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_we_q    <= 1'b0;
            s_size_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            ready_q   <= '0;
            grant_q   <= '0;
            gnt_oh_q  <= '0;
            rr_q      <= '0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            s_valid_q <= s_valid_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_we_q    <= s_we_d;
            s_size_q  <= s_size_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            grant_q   <= grant_d;
            gnt_oh_q  <= gnt_oh_d;
            rr_q      <= rr_d;
            wdog_q    <= wdog_d;
        end
    end

    assign m_req_ready = ready_q;
    assign m_req_rdata = rdata_q;
    assign m_req_err   = err_q;
    assign s_req_valid = s_valid_q;
    assign s_req_addr  = s_addr_q;
    assign s_req_wdata = s_wdata_q;
    assign s_req_we    = s_we_q;
    assign s_req_size  = s_size_q;
    assign busy        = (state_q != IDLE);
    assign grant_id    = grant_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clint_bus_arbiter.sv
// Bench for clint_bus_arbiter: transaction-level model of arbitration, latency and timeout.
`timescale 1ns/1ps
module tb_clint_bus_arbiter;
    import clint_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int TO = 16;
    localparam logic [15:0] MTIME_A = 16'hBFF8;

    typedef struct packed {
        logic          we;
        logic [15:0]   addr;
        logic [63:0]   wdata;
        logic [2:0]    size;
    } op_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mtime = 64'd0;
    always @(posedge clk) mtime <= mtime + 64'd1;

    // ---------------- DUT signals ----------------
    logic [N-1:0]     req_v;
    logic [AW-1:0]    r_addr  [N];
    logic [DW-1:0]    r_wdata [N];
    logic             r_we    [N];
    logic [2:0]       r_size  [N];
    logic [N*AW-1:0]  m_req_addr;
    logic [N*DW-1:0]  m_req_wdata;
    logic [N-1:0]     m_req_we;
    logic [N*3-1:0]   m_req_size;
    logic [N-1:0]     m_req_ready;
    logic [DW-1:0]    m_req_rdata;
    logic             m_req_err;
    logic             s_req_valid;
    logic [AW-1:0]    s_req_addr;
    logic [DW-1:0]    s_req_wdata;
    logic             s_req_we;
    logic [2:0]       s_req_size;
    logic             s_req_ready;
    logic [DW-1:0]    s_req_rdata;
    logic             busy;
    logic [0:0]       grant_id;
    state_t           dbg_state;

    assign m_req_addr  = {r_addr[1], r_addr[0]};
    assign m_req_wdata = {r_wdata[1], r_wdata[0]};
    assign m_req_we    = {r_we[1], r_we[0]};
    assign m_req_size  = {r_size[1], r_size[0]};

    clint_bus_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m_req_valid(req_v), .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
        .m_req_we(m_req_we), .m_req_size(m_req_size),
        .m_req_ready(m_req_ready), .m_req_rdata(m_req_rdata), .m_req_err(m_req_err),
        .s_req_valid(s_req_valid), .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
        .s_req_we(s_req_we), .s_req_size(s_req_size),
        .s_req_ready(s_req_ready), .s_req_rdata(s_req_rdata),
        .busy(busy), .grant_id(grant_id), .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    int n_cmp = 0;
    int n_err = 0;

    op_t q0[$];
    op_t q1[$];
    logic [63:0] exp_q[$];          // expected read data of the transaction in flight
    logic [63:0] mem_m [logic [15:0]];
    logic [63:0] smem  [logic [15:0]];
    logic [N-1:0] pending;
    int   mst;                      // 0 free, 1 waiting for completion, 1-cycle tail = 2
    int   mptr, w, wcnt, exp_l;
    logic exp_err;
    op_t  snap;
    logic [63:0] last_mtime = 64'd0;
    logic [63:0] hold_exp;
    logic hold_chk;
    int   scyc, slv_lat, fixed_lat;
    bit   rand_lat, rand_gap, abandon_next;
    logic [15:0] addr_tab [5];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load_req(input int i);
        op_t op;
        op = (i == 0) ? q0.pop_front() : q1.pop_front();
        r_addr[i]  = op.addr;
        r_wdata[i] = op.wdata;
        r_we[i]    = op.we;
        r_size[i]  = op.size;
        req_v[i]   = 1'b1;
        pending[i] = 1'b1;
    endtask

    task automatic push_op(input int i, input logic we, input logic [15:0] a,
                           input logic [63:0] d, input logic [2:0] sz);
        op_t op;
        op.we = we; op.addr = a; op.wdata = d; op.size = sz;
        if (i == 0) q0.push_back(op); else q1.push_back(op);
    endtask

    // One clock of model, requester drivers and slave, evaluated at the falling edge.
    task automatic step();
        logic [N-1:0] done_mask;
        logic [63:0]  e;
        @(negedge clk);
        done_mask = '0;
        if (mst == 0) begin
            if (req_v != '0) begin
                w = pick(req_v, mptr);
                snap.we = r_we[w]; snap.addr = r_addr[w];
                snap.wdata = r_wdata[w]; snap.size = r_size[w];
                slv_lat = rand_lat ? (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20)))
                                   : fixed_lat;
                exp_err = (slv_lat == 0) || (slv_lat > TO);
                exp_l   = exp_err ? TO : slv_lat;
                if (exp_err)          e = ERR_RDATA;
                else if (snap.we)     e = 64'd0;
                else if (snap.addr == MTIME_A) e = 64'd0;
                else                  e = mem_m.exists(snap.addr) ? mem_m[snap.addr] : 64'd0;
                exp_q.push_back(e);
                check("grant_id", 64'(grant_id), 64'(w));
                check("grant_s_valid", 64'(s_req_valid), 64'd1);
                check("grant_s_addr", 64'(s_req_addr), 64'(snap.addr));
                check("grant_s_wdata", s_req_wdata, snap.wdata);
                check("grant_s_we", 64'(s_req_we), 64'(snap.we));
                check("grant_s_size", 64'(s_req_size), 64'(snap.size));
                mst = 1;
                wcnt = 0;
                if (abandon_next && w == 0) begin
                    req_v[0]  = 1'b0;
                    r_addr[0] = ~r_addr[0];
                    abandon_next = 1'b0;
                end
            end else begin
                check("idle_busy", 64'(busy), 64'd0);
            end
        end else if (mst == 1) begin
            wcnt++;
            if (m_req_ready != '0 || wcnt >= exp_l) begin
                e = exp_q.pop_front();
                check("cpl_cycle", 64'(wcnt), 64'(exp_l));
                check("cpl_onehot", 64'(m_req_ready), 64'(1 << w));
                check("cpl_err", 64'(m_req_err), 64'(exp_err));
                check("cpl_s_valid", 64'(s_req_valid), 64'd0);
                hold_chk = 1'b1;
                hold_exp = e;
                if (!exp_err && !snap.we && snap.addr == MTIME_A) begin
                    check("mtime_mono", 64'(m_req_rdata > last_mtime), 64'd1);
                    last_mtime = m_req_rdata;
                    hold_chk = 1'b0;
                end else begin
                    check("cpl_rdata", m_req_rdata, e);
                end
                if (!exp_err && snap.we) mem_m[snap.addr] = snap.wdata;
                req_v[w] = 1'b0;
                pending[w] = 1'b0;
                done_mask[w] = 1'b1;
                mptr = (w + 1) % N;
                mst = 2;
            end else begin
                check("wait_s_addr", 64'(s_req_addr), 64'(snap.addr));
                check("wait_s_valid", 64'(s_req_valid), 64'd1);
                check("wait_busy", 64'(busy), 64'd1);
            end
        end else begin
            check("tail_ready", 64'(m_req_ready), 64'd0);
            check("tail_err", 64'(m_req_err), 64'd0);
            check("tail_busy", 64'(busy), 64'd0);
            if (hold_chk) check("rdata_hold", m_req_rdata, hold_exp);
            mst = 0;
        end
        for (int i = 0; i < N; i++)
            if (!pending[i] && !done_mask[i] && qsize(i) > 0 &&
                (!rand_gap || $urandom_range(0, 2) == 0))
                load_req(i);
        // Slave: asserts ready in the slv_lat-th cycle of a held request (0 = never).
        if (s_req_valid) begin
            scyc++;
            if (slv_lat != 0 && scyc == slv_lat) begin
                s_req_ready = 1'b1;
                if (s_req_we) begin
                    smem[s_req_addr] = s_req_wdata;
                    s_req_rdata = 64'd0;
                end else if (s_req_addr == MTIME_A) begin
                    s_req_rdata = mtime;
                end else begin
                    s_req_rdata = smem.exists(s_req_addr) ? smem[s_req_addr] : 64'd0;
                end
            end else begin
                s_req_ready = 1'b0;
                s_req_rdata = {$urandom, $urandom};
            end
        end else begin
            scyc = 0;
            s_req_ready = 1'b0;
            s_req_rdata = {$urandom, $urandom};
        end
    endtask

    task automatic run_seg(input string tag, input int budget);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && pending == '0 && mst == 0) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done"}, 64'(n < budget), 64'd1);
    endtask

    task automatic clear_env();
        req_v = '0; pending = '0; mst = 0; mptr = 0; scyc = 0;
        s_req_ready = 1'b0; s_req_rdata = '0;
        q0.delete(); q1.delete(); exp_q.delete();
        hold_chk = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- main sequence ----------------
    initial begin
        addr_tab[0] = 16'h0000; addr_tab[1] = 16'h0008; addr_tab[2] = 16'h4000;
        addr_tab[3] = 16'h4008; addr_tab[4] = MTIME_A;
        for (int i = 0; i < N; i++) begin
            r_addr[i] = '0; r_wdata[i] = '0; r_we[i] = 1'b0; r_size[i] = '0;
        end
        rand_lat = 1'b0; rand_gap = 1'b0; abandon_next = 1'b0; fixed_lat = 1; slv_lat = 1;
        clear_env();
        repeat (3) @(negedge clk);
        check("rst_s_valid", 64'(s_req_valid), 64'd0);
        check("rst_m_ready", 64'(m_req_ready), 64'd0);
        check("rst_m_err", 64'(m_req_err), 64'd0);
        check("rst_m_rdata", m_req_rdata, 64'd0);
        check("rst_s_addr", 64'(s_req_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));

        // Both requesters contend for mtime reads; grants must alternate.
        for (int k = 0; k < 4; k++) begin
            push_op(0, 1'b0, MTIME_A, 64'd0, SIZE_W64);
            push_op(1, 1'b0, MTIME_A, 64'd0, SIZE_W64);
        end
        load_req(0); load_req(1);
        reset_n = 1'b1;
        run_seg("rr_mtime", 400);

        // Single write then readback by requester 1, slave ready on 2nd ISSUE cycle.
        fixed_lat = 2;
        push_op(1, 1'b1, 16'h4008, 64'h1234, SIZE_W64);
        run_seg("wr4008", 100);
        push_op(1, 1'b0, 16'h4008, 64'd0, SIZE_W64);
        run_seg("rd4008", 100);

        // Hung slave: watchdog completion, then a normal access.
        fixed_lat = 0;
        push_op(0, 1'b0, 16'h0000, 64'd0, SIZE_W32);
        run_seg("timeout", 100);
        fixed_lat = 1;
        push_op(0, 1'b0, 16'h4008, 64'd0, SIZE_W64);
        run_seg("after_to", 100);

        // Ready coincides with watchdog expiry (ready wins), then one cycle too late.
        fixed_lat = TO;
        push_op(1, 1'b0, 16'h4008, 64'd0, SIZE_W64);
        run_seg("same_cycle", 100);
        fixed_lat = TO + 1;
        push_op(1, 1'b1, 16'h4000, 64'hDEAD, SIZE_W64);
        run_seg("late_ready", 100);

        // Requester 0 drops valid and changes address right after grant.
        fixed_lat = 3;
        abandon_next = 1'b1;
        push_op(0, 1'b1, 16'h0008, 64'hCAFE_F00D, SIZE_W64);
        run_seg("abandon", 100);
        push_op(1, 1'b0, 16'h0008, 64'd0, SIZE_W64);
        run_seg("abandon_rd", 100);

        // Reset during ISSUE after the pointer has moved to requester 1.
        fixed_lat = 1;
        push_op(0, 1'b0, 16'h4008, 64'd0, SIZE_W64);
        run_seg("pre_rst", 100);
        fixed_lat = 0;
        push_op(1, 1'b0, 16'h0000, 64'd0, SIZE_W64);
        for (int k = 0; k < 20 && !(mst == 1 && wcnt >= 3); k++) step();
        check("rst_setup_issue", 64'(mst == 1), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_s_valid", 64'(s_req_valid), 64'd0);
        check("midrst_m_ready", 64'(m_req_ready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        clear_env();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        fixed_lat = 1;
        push_op(0, 1'b0, 16'h4008, 64'd0, SIZE_W64);
        push_op(1, 1'b0, 16'h0008, 64'd0, SIZE_W64);
        run_seg("post_rst", 100);

        // Randomized traffic: random gaps, payloads and slave latencies.
        rand_lat = 1'b1;
        rand_gap = 1'b1;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 25; k++) begin
                logic [15:0] a;
                logic        we;
                a  = addr_tab[$urandom_range(0, 4)];
                we = (a == MTIME_A) ? 1'b0 : 1'($urandom_range(0, 1));
                push_op(i, we, a, {$urandom, $urandom}, $urandom_range(0, 1) ? SIZE_W64 : SIZE_W32);
            end
        run_seg("random", 5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
